// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings, control width and FSM states for alu_mdu
package alu_pkg;

  localparam int ALU_CTRL_W = 5;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD    = 5'h00;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB    = 5'h01;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND    = 5'h02;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR     = 5'h03;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR    = 5'h04;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT    = 5'h05;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU   = 5'h06;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL    = 5'h07;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL    = 5'h08;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA    = 5'h09;
  localparam logic [ALU_CTRL_W-1:0] ALU_MUL    = 5'h0A;
  localparam logic [ALU_CTRL_W-1:0] ALU_MULH   = 5'h0B;
  localparam logic [ALU_CTRL_W-1:0] ALU_MULHSU = 5'h0C;
  localparam logic [ALU_CTRL_W-1:0] ALU_MULHU  = 5'h0D;
  localparam logic [ALU_CTRL_W-1:0] ALU_DIV    = 5'h0E;
  localparam logic [ALU_CTRL_W-1:0] ALU_DIVU   = 5'h0F;
  localparam logic [ALU_CTRL_W-1:0] ALU_REM    = 5'h10;
  localparam logic [ALU_CTRL_W-1:0] ALU_REMU   = 5'h11;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } alu_state_e;

  function automatic logic is_mul_op(input logic [ALU_CTRL_W-1:0] op);
    return (op >= ALU_MUL) && (op <= ALU_MULHU);
  endfunction

  function automatic logic is_div_op(input logic [ALU_CTRL_W-1:0] op);
    return (op >= ALU_DIV) && (op <= ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// rtl/alu_mdu_if.sv - request/response handshake bundle between control path and alu_mdu
interface alu_mdu_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic                  i_valid;
  logic                  o_ready;
  logic [ALU_CTRL_W-1:0] i_alu_ctrl;
  logic [WIDTH-1:0]      i_srca;
  logic [WIDTH-1:0]      i_srcb;
  logic                  o_valid;
  logic                  i_ready;
  logic [WIDTH-1:0]      o_alu_result;
  logic                  o_zero;

  modport master (
    output i_valid, i_alu_ctrl, i_srca, i_srcb, i_ready,
    input  o_ready, o_valid, o_alu_result, o_zero
  );

  modport slave (
    input  i_valid, i_alu_ctrl, i_srca, i_srcb, i_ready,
    output o_ready, o_valid, o_alu_result, o_zero
  );

endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational single-cycle ops (ADD..SRA); any other opcode yields 0
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [ALU_CTRL_W-1:0] i_alu_ctrl,
  input  logic [WIDTH-1:0]      i_srca,
  input  logic [WIDTH-1:0]      i_srcb,
  output logic [WIDTH-1:0]      o_result
);

  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0] w_shamt;
  assign w_shamt = i_srcb[SH_W-1:0];

  always_comb begin
    o_result = '0;
    case (i_alu_ctrl)
      ALU_ADD:  o_result = i_srca + i_srcb;
      ALU_SUB:  o_result = i_srca - i_srcb;
      ALU_AND:  o_result = i_srca & i_srcb;
      ALU_OR:   o_result = i_srca | i_srcb;
      ALU_XOR:  o_result = i_srca ^ i_srcb;
      ALU_SLT:  o_result = {{(WIDTH-1){1'b0}}, ($signed(i_srca) < $signed(i_srcb))};
      ALU_SLTU: o_result = {{(WIDTH-1){1'b0}}, (i_srca < i_srcb)};
      ALU_SLL:  o_result = i_srca << w_shamt;
      ALU_SRL:  o_result = i_srca >> w_shamt;
      ALU_SRA:  o_result = $unsigned($signed(i_srca) >>> w_shamt);
      default:  o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - multi-cycle ALU with bit-serial multiply/divide and registered result
// Divider and its fast-path exist only when ALU_MDU_DIV_EN is defined.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic      i_clk,
  input logic      i_rst,
  alu_mdu_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  alu_state_e            r_state;
  alu_state_e            w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [ALU_CTRL_W-1:0] r_op;
  logic                  r_neg;
  logic                  r_is_div;
  logic [WIDTH-1:0]      r_a;
  logic [2*WIDTH-1:0]    r_acc;
  logic [WIDTH-1:0]      r_result;
  logic                  r_zero;

  logic [ALU_CTRL_W-1:0] w_op;
  logic [WIDTH-1:0]      w_a;
  logic [WIDTH-1:0]      w_b;
  logic [WIDTH-1:0]      w_core_res;

  assign w_op = bus.i_alu_ctrl;
  assign w_a  = bus.i_srca;
  assign w_b  = bus.i_srcb;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .i_alu_ctrl (w_op),
    .i_srca     (w_a),
    .i_srcb     (w_b),
    .o_result   (w_core_res)
  );

  // Iteration runs on magnitudes; r_neg remembers whether the final value must be negated
  logic             w_a_signed;
  logic             w_b_signed;
  logic             w_neg;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;

  assign w_a_signed = (w_op == ALU_MULH) || (w_op == ALU_MULHSU) || (w_op == ALU_DIV) || (w_op == ALU_REM);
  assign w_b_signed = (w_op == ALU_MULH) || (w_op == ALU_DIV) || (w_op == ALU_REM);
  assign w_mag_a    = (w_a_signed && w_a[WIDTH-1]) ? -w_a : w_a;
  assign w_mag_b    = (w_b_signed && w_b[WIDTH-1]) ? -w_b : w_b;
  assign w_neg      = (w_op == ALU_REM) ? w_a[WIDTH-1]
                    : ((w_a_signed & w_a[WIDTH-1]) ^ (w_b_signed & w_b[WIDTH-1]));

  // Shift-add: acc = {partial product, remaining multiplier bits}
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_mul_res;

  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
  assign w_prod     = r_neg ? -w_mul_next : w_mul_next;
  assign w_mul_res  = (r_op == ALU_MUL) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];

  logic             w_div_op;
  logic             w_fast;
  logic [WIDTH-1:0] w_fast_res;
  logic [WIDTH-1:0] w_div_res;

`ifdef ALU_MDU_DIV_EN
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic               w_div_q_op;
  logic               w_div_by_zero;
  logic               w_div_ovf;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic               w_q_sel;
  logic [WIDTH-1:0]   w_div_sel;

  assign w_div_op      = is_div_op(w_op);
  assign w_div_q_op    = (w_op == ALU_DIV) || (w_op == ALU_DIVU);
  assign w_div_by_zero = (w_b == '0);
  assign w_div_ovf     = ((w_op == ALU_DIV) || (w_op == ALU_REM)) && (w_a == MIN_NEG) && (w_b == '1);
  assign w_fast        = w_div_op && (w_div_by_zero || w_div_ovf);

  always_comb begin
    w_fast_res = '0;
    if (w_div_by_zero) begin
      w_fast_res = w_div_q_op ? '1 : w_a;
    end else if (w_div_ovf) begin
      w_fast_res = w_div_q_op ? w_a : '0;
    end
  end

  // Restoring step: acc = {partial remainder, dividend bits shifting into quotient}
  assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_a};
  assign w_div_next = w_diff[WIDTH] ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};
  assign w_q_sel    = (r_op == ALU_DIV) || (r_op == ALU_DIVU);
  assign w_div_sel  = w_q_sel ? w_div_next[WIDTH-1:0] : w_div_next[2*WIDTH-1:WIDTH];
  assign w_div_res  = r_neg ? -w_div_sel : w_div_sel;
`else
  assign w_div_op   = 1'b0;
  assign w_fast     = 1'b0;
  assign w_fast_res = '0;
  assign w_div_res  = '0;
`endif

  logic             w_go_calc;
  logic [WIDTH-1:0] w_idle_res;
  logic [WIDTH-1:0] w_final;

  assign w_go_calc  = is_mul_op(w_op) || (w_div_op && !w_fast);
  assign w_idle_res = w_fast ? w_fast_res : w_core_res;
  assign w_final    = r_is_div ? w_div_res : w_mul_res;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    bus.o_ready = 1'b0;
    bus.o_valid = 1'b0;
    case (r_state)
      IDLE: begin
        bus.o_ready = 1'b1;
        if (bus.i_valid) begin
          w_next = w_go_calc ? CALC : DONE;
        end
      end
      CALC: begin
        if (r_cnt == CNT_W'(1)) begin
          w_next = DONE;
        end
      end
      DONE: begin
        bus.o_valid = 1'b1;
        if (bus.i_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_is_div <= 1'b0;
      r_a      <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.i_valid) begin
            r_op     <= w_op;
            r_neg    <= w_neg;
            r_is_div <= w_div_op;
            r_a      <= w_div_op ? w_mag_b : w_mag_a;
            r_acc    <= {{WIDTH{1'b0}}, (w_div_op ? w_mag_a : w_mag_b)};
            if (w_go_calc) begin
              r_cnt <= CNT_W'(WIDTH);
            end else begin
              r_result <= w_idle_res;
              r_zero   <= ~|w_idle_res;
            end
          end
        end
        CALC: begin
          r_acc <= r_is_div ? w_div_next_or_mul() : w_mul_next;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_result <= w_final;
            r_zero   <= ~|w_final;
          end
        end
        default: ;
      endcase
    end
  end

  function automatic logic [2*WIDTH-1:0] w_div_next_or_mul();
`ifdef ALU_MDU_DIV_EN
    return w_div_next;
`else
    return w_mul_next;
`endif
  endfunction

  assign bus.o_alu_result = r_result;
  assign bus.o_zero       = r_zero;

endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - randomized self-checking bench for alu_mdu against a plain-arithmetic model
module tb_alu_mdu;
  import alu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_mdu_if #(.WIDTH(W)) bus ();

  alu_mdu #(.WIDTH(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic div_enabled();
`ifdef ALU_MDU_DIV_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'h0, a});
    ub  = longint'({32'h0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (op >= 5'h0E && op <= 5'h11 && !div_enabled()) return 32'h0;
    case (op)
      5'h00: return a + b;
      5'h01: return a - b;
      5'h02: return a & b;
      5'h03: return a | b;
      5'h04: return a ^ b;
      5'h05: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'h06: return (a < b) ? 32'd1 : 32'd0;
      5'h07: return a << b[4:0];
      5'h08: return a >> b[4:0];
      5'h09: return $unsigned($signed(a) >>> b[4:0]);
      5'h0A: begin p = 64'(sa * sb); return p[31:0];  end
      5'h0B: begin p = 64'(sa * sb); return p[63:32]; end
      5'h0C: begin p = 64'(sa * ub); return p[63:32]; end
      5'h0D: begin p = 64'(ua * ub); return p[63:32]; end
      5'h0E: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      5'h0F: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'h10: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      5'h11: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int model_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (op == 5'h0E || op == 5'h10) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (op >= 5'h0A && op <= 5'h0D) return W + 1;
    if (div_enabled() && op >= 5'h0E && op <= 5'h11 && b != 0 && !ovf) return W + 1;
    return 1;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Caller is #1 after a rising edge with the DUT expected in IDLE
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [31:0] exp;
    int lat;
    exp = model(op, a, b);
    check_eq({tag, "_rdy"}, 32'(bus.o_ready), 32'd1);
    bus.i_valid    = 1'b1;
    bus.i_alu_ctrl = op;
    bus.i_srca     = a;
    bus.i_srcb     = b;
    bus.i_ready    = (hold == 0);
    @(posedge clk); #1;
    bus.i_valid    = 1'b0;
    bus.i_srca     = $urandom;
    bus.i_srcb     = $urandom;
    bus.i_alu_ctrl = 5'($urandom);
    lat = 1;
    while (!bus.o_valid && lat < 60) begin
      if (lat == 2) check_eq({tag, "_busy"}, 32'(bus.o_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'(model_lat(op, a, b)));
    check_eq({tag, "_res"}, bus.o_alu_result, exp);
    check_eq({tag, "_zero"}, 32'(bus.o_zero), 32'(exp == 0));
    if (hold > 0) begin
      bus.i_valid    = 1'b1;
      bus.i_alu_ctrl = ALU_ADD;
      repeat (hold) begin @(posedge clk); #1; end
      check_eq({tag, "_hold_v"}, 32'(bus.o_valid), 32'd1);
      check_eq({tag, "_hold_res"}, bus.o_alu_result, exp);
      check_eq({tag, "_hold_rdy"}, 32'(bus.o_ready), 32'd0);
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
    end
    @(posedge clk); #1;
    check_eq({tag, "_idle_v"}, 32'(bus.o_valid), 32'd0);
    check_eq({tag, "_idle_rdy"}, 32'(bus.o_ready), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_v"}, 32'(bus.o_valid), 32'd0);
    check_eq({tag, "_rdy"}, 32'(bus.o_ready), 32'd1);
    check_eq({tag, "_res"}, bus.o_alu_result, 32'd0);
    check_eq({tag, "_zero"}, 32'(bus.o_zero), 32'd1);
  endtask

  task automatic reset_mid_op(input string tag, input logic [4:0] op);
    run_op({tag, "_pre"}, ALU_OR, 32'h00F0_0000, 32'h0000_000F, 0);
    bus.i_valid    = 1'b1;
    bus.i_alu_ctrl = op;
    bus.i_srca     = 32'hDEAD_BEEF;
    bus.i_srcb     = 32'h0000_0123;
    bus.i_ready    = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state(tag);
    repeat (40) begin @(posedge clk); #1; end
    check_eq({tag, "_discard"}, 32'(bus.o_valid), 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.i_valid    = 1'b0;
    bus.i_ready    = 1'b0;
    bus.i_alu_ctrl = '0;
    bus.i_srca     = '0;
    bus.i_srcb     = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("reset");

    run_op("add",    ALU_ADD,    32'd5,         32'd7,         0);
    run_op("sub",    ALU_SUB,    32'd7,         32'd7,         0);
    run_op("sra",    ALU_SRA,    32'h8000_0000, 32'h0000_0021, 0);
    run_op("slt",    ALU_SLT,    32'hFFFF_FFFF, 32'd1,         0);
    run_op("sltu",   ALU_SLTU,   32'hFFFF_FFFF, 32'd1,         0);
    run_op("mulh",   ALU_MULH,   32'h8000_0000, 32'h8000_0000, 0);
    run_op("mul",    ALU_MUL,    32'hFFFF_FFFD, 32'd7,         0);
    run_op("mulhsu", ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("div",    ALU_DIV,    32'hFFFF_FFF9, 32'd2,         0);
    run_op("rem",    ALU_REM,    32'hFFFF_FFF9, 32'd2,         0);
    run_op("div0",   ALU_DIV,    32'h1234_5678, 32'd0,         0);
    run_op("remu0",  ALU_REMU,   32'h1234_5678, 32'd0,         0);
    run_op("divovf", ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("removf", ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("divu",   ALU_DIVU,   32'hFFFF_FFFF, 32'd10,        0);
    run_op("undef",  5'h15,      32'h1234_5678, 32'h1,         0);
    run_op("hold",   ALU_XOR,    32'hA5A5_0000, 32'h0000_5A5A, 10);
    run_op("holdm",  ALU_MULHU,  32'hFFFF_FFFF, 32'h0000_0003, 3);
    run_op("after",  ALU_SLL,    32'h0000_0001, 32'h0000_001F, 0);

    reset_mid_op("rst_divu", ALU_DIVU);
    reset_mid_op("rst_mulhu", ALU_MULHU);

    for (int i = 0; i < 300; i++) begin
      logic [4:0] op;
      int hold;
      op   = 5'($urandom_range(0, 31));
      hold = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
      run_op($sformatf("rnd%0d_op%0h", i, op), op, pick_operand(), pick_operand(), hold);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised, multi-cycle successor to the single-cycle datapath ALU: full RV32I/M-style integer ALU with shifts, signed/unsigned compares, and iterative multiply/divide. It sits in the execute stage and talks to the control path through a valid/ready handshake. Simple ops complete in one cycle. Multiply/divide iterate one bit per cycle. Results and the zero flag are registered and held until consumed.

## Interface
- WIDTH, 32: operand/result width; power of two, ≥ 8.
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  operation request.
- o_ready  out  1  block can accept a request (high only in IDLE).
- i_alu_ctrl  in  5  opcode (alu_pkg encodings).
- i_srca, i_srcb  in  WIDTH  operands, sampled on accept.
- o_valid  out  1  o_alu_result/o_zero valid.
- i_ready  in  1  consumer takes result.
- o_alu_result  out  WIDTH  registered result.
- o_zero  out  1  registered, equals ~|o_alu_result.

## Operation
- Opcodes:
  - 00 ADD, 01 SUB, 02 AND, 03 OR, 04 XOR, 05 SLT (signed), 06 SLTU, 07 SLL, 08 SRL, 09 SRA.
  - 0A MUL (low WIDTH), 0B MULH (s×s high), 0C MULHSU (s×u high), 0D MULHU (u×u high).
  - 0E DIV, 0F DIVU, 10 REM, 11 REMU.
  - 12–1F undefined: result 0, o_zero 1, single-cycle.
- Shifts use srcb[$clog2(WIDTH)-1:0]. SLT/SLTU produce 1 or 0, zero-extended.
- FSM:
  - IDLE: on i_valid, latch operands/op.
    - Simple, undefined or division fast-path → DONE.
    - Mul/div → CALC with counter = WIDTH.
  - CALC: one step per cycle, decrement counter. At counter==1, apply sign fix-up, register result → DONE.
  - DONE: o_valid=1, outputs stable. On i_ready → IDLE.
- Multiply: shift-add on magnitudes into a 2·WIDTH accumulator. Negate the product if operand signs differ (signed operands only).
- Divide: restoring, on magnitudes.
  - Quotient sign = sign(a)^sign(b).
  - Remainder sign = sign(a).
- Division fast-path (resolved in IDLE, no CALC):
  - Divisor 0: DIV/DIVU → all ones; REM/REMU → dividend.
  - Signed overflow (a = −2^(WIDTH−1), b = −1): DIV → a; REM → 0.
- i_valid while o_ready=0 is ignored; the requester holds it.

## Timing
- Reset values: o_valid 0, o_ready 1 (state IDLE), o_alu_result 0, o_zero 1, counter 0.
- Latency is measured from the accepting edge (i_valid & o_ready) to o_valid high:
  - 1 cycle for simple, undefined and fast-path ops.
  - WIDTH+1 cycles for mul/div (33 for WIDTH=32).
- Throughput:
  - Simple op: 1 per 2 cycles minimum (DONE→IDLE, then accept).
  - Mul/div: 1 per WIDTH+2 cycles.
- o_valid held with stable data while i_ready=0 (any number of cycles).
- i_ready when o_valid=0 has no effect.
- i_rst mid-CALC or in DONE: next edge → IDLE, all outputs at reset values, in-flight op discarded.
- Operand inputs may change freely after the accept edge.

## Configuration
- ALU_MDU_DIV_EN:
  - Defined: divider datapath and fast-path compiled in; opcodes 0E–11 as above.
  - Undefined: no divider logic. 0E–11 behave as undefined opcodes (result 0, 1-cycle latency). Multiply unaffected.

## Structure
- alu_pkg:
  - Opcode localparams (ALU_ADD … ALU_REMU).
  - ALU_CTRL_W = 5.
  - FSM state typedef {IDLE, CALC, DONE}.
- Sub-module alu_core: combinational single-cycle ops (00–09), WIDTH-parametrised.
- alu_mdu holds the FSM, the iterative mul/div datapath and the output registers.

## Test plan
- Reset, then ADD 5+7 with i_ready=1 → o_valid one cycle after accept, result 12, o_zero 0. SUB 7−7 → 0, o_zero 1.
- SRA 0x80000000 by srcb=0x21 (amount 1) → 0xC0000000. SLT −1<1 → 1. SLTU 0xFFFFFFFF<1 → 0.
- MULH 0x80000000×0x80000000 → 0x40000000. MUL −3×7 → 0xFFFFFFEB. Both with o_valid exactly 33 cycles after accept; o_ready low throughout.
- DIV −7/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF. DIV x/0 → 0xFFFFFFFF in 1 cycle. DIV 0x80000000/−1 → 0x80000000, REM → 0.
- Hold i_ready=0 for 10 cycles in DONE → result stable, o_ready 0, new i_valid ignored. i_ready=1 → IDLE, next request accepted.
- Assert i_rst at CALC cycle 15 of DIVU → next cycle IDLE, o_valid 0, result 0, o_zero 1. Repeat the test with ALU_MDU_DIV_EN undefined → opcode 0E returns 0 in 1 cycle.
